// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared RISC-V core definitions used by the hazard/forwarding controller.
//   REG_AW  : register address width (x0..x31)
//   FWD_*   : select encodings for the 3:1 operand muxes ahead of the ALU
//             (i1 = register file, i2 = Result_W, i3 = ALUResult_M)
package riscv_pkg;
    localparam int         REG_AW = 5;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/forwarding controller.
//   D-stage fields : rs1_d, rs2_d, rd_d, regwrite_d, load_d
//   EX-stage input : pcsrc_e (branch/jump taken)
//   Controls       : forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
//   Status         : stall_cnt (saturating load-use stall count)
// master = datapath side, slave = controller side.
interface hazard_forward_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic              regwrite_d;
    logic              load_d;
    logic              pcsrc_e;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
        input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
        output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand.
//   rs          : source register of the instruction in EX
//   rd_m/_w     : destination tags of the instructions in MEM / WB
//   regwrite_m/_w : those instructions write their rd
//   sel         : FWD_M when MEM holds the value, else FWD_W, else FWD_RF
// MEM is checked first because it holds the youngest value; x0 is never forwarded.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output logic [1:0]        sel
);
    always_comb begin
        sel = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage core.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of hazard_forward_ctrl_if (D-stage fields and
//              pcsrc_e in; operand selects, stall/flush controls and the
//              load-use stall counter out)
// Keeps a private E/M/W copy of register tags so only decode fields and the
// branch-taken flag are needed from the datapath.
module hazard_forward_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);
    // Tag pipeline
    logic [REG_AW-1:0] rs1EReg, rs2EReg, rdEReg, rdMReg, rdWReg;
    logic              regWriteEReg, loadEReg, regWriteMReg, regWriteWReg;
    logic [CNT_W-1:0]  stallCntReg;

    logic              lwStall;
    logic [REG_AW-1:0] rsE  [2];
    logic [1:0]        fwdSel [2];

    assign rsE[0] = rs1EReg;
    assign rsE[1] = rs2EReg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_fwd
            fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
                .rs         (rsE[gi]),
                .rd_m       (rdMReg),
                .regwrite_m (regWriteMReg),
                .rd_w       (rdWReg),
                .regwrite_w (regWriteWReg),
                .sel        (fwdSel[gi])
            );
        end
    endgenerate

    assign bus.forward_a_e = fwdSel[0];
    assign bus.forward_b_e = fwdSel[1];

    // A load in EX whose result the D instruction needs cannot be forwarded in
    // time; one bubble moves the load to MEM so the value arrives via WB.
    assign lwStall = loadEReg && (rdEReg != '0) &&
                     ((rdEReg == bus.rs1_d) || (rdEReg == bus.rs2_d));

    // A taken branch kills both younger instructions; stalling would be pointless.
    assign bus.stall_f   = lwStall && !bus.pcsrc_e;
    assign bus.stall_d   = lwStall && !bus.pcsrc_e;
    assign bus.flush_d   = bus.pcsrc_e;
    assign bus.flush_e   = bus.pcsrc_e || lwStall;
    assign bus.stall_cnt = stallCntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1EReg      <= '0;
            rs2EReg      <= '0;
            rdEReg       <= '0;
            regWriteEReg <= 1'b0;
            loadEReg     <= 1'b0;
            rdMReg       <= '0;
            regWriteMReg <= 1'b0;
            rdWReg       <= '0;
            regWriteWReg <= 1'b0;
            stallCntReg  <= '0;
        end else begin
            rdWReg       <= rdMReg;
            regWriteWReg <= regWriteMReg;
            rdMReg       <= rdEReg;
            regWriteMReg <= regWriteEReg;
            if (bus.flush_e) begin
                rs1EReg      <= '0;
                rs2EReg      <= '0;
                rdEReg       <= '0;
                regWriteEReg <= 1'b0;
                loadEReg     <= 1'b0;
            end else begin
                rs1EReg      <= bus.rs1_d;
                rs2EReg      <= bus.rs2_d;
                rdEReg       <= bus.rd_d;
                regWriteEReg <= bus.regwrite_d;
                loadEReg     <= bus.load_d;
            end
            if (lwStall && !bus.pcsrc_e && (stallCntReg != '1)) begin
                stallCntReg <= stallCntReg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifc16 ();
    hazard_forward_ctrl_if #(.REG_AW(5), .CNT_W(2))  ifc2 ();

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (ifc16.slave)
    );

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the list of instructions that entered EX, newest first.
    // Index 0 is in EX, 1 in MEM, 2 in WB.
    instr_t hist[$];
    int     cnt16;
    int     cnt2;
    instr_t curD;
    logic   curPc;
    logic   expFlushE;
    logic   expLw;

    // Operand-mux model fed by forward_*: i1 regfile, i2 Result_W, i3 ALUResult_M
    logic [31:0] muxA;
    always_comb begin
        case (ifc16.forward_a_e)
            2'b00:   muxA = 32'h1111_0000;
            2'b01:   muxA = 32'h2222_0000;
            2'b10:   muxA = 32'h3333_0000;
            default: muxA = 32'hdead_beef;
        endcase
    end

    function automatic instr_t mk(int rs1, int rs2, int rd, bit rw, bit ld);
        instr_t t;
        t.rs1 = rs1[4:0];
        t.rs2 = rs2[4:0];
        t.rd  = rd[4:0];
        t.rw  = rw;
        t.ld  = ld;
        return t;
    endfunction

    function automatic logic [1:0] modelFwd(logic [4:0] rs);
        // Youngest older producer that writes a nonzero rs supplies the value.
        if (hist[1].rw && hist[1].rd != 0 && hist[1].rd == rs) return 2'b10;
        if (hist[2].rw && hist[2].rd != 0 && hist[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('0);
        cnt16 = 0;
        cnt2  = 0;
    endtask

    // Drive D fields / pcsrc, then compare every output against the model.
    task automatic step(instr_t d, bit pc);
        logic [1:0] ea, eb;
        curD  = d;
        curPc = pc;
        ifc16.rs1_d = d.rs1; ifc16.rs2_d = d.rs2; ifc16.rd_d = d.rd;
        ifc16.regwrite_d = d.rw; ifc16.load_d = d.ld; ifc16.pcsrc_e = pc;
        ifc2.rs1_d = d.rs1; ifc2.rs2_d = d.rs2; ifc2.rd_d = d.rd;
        ifc2.regwrite_d = d.rw; ifc2.load_d = d.ld; ifc2.pcsrc_e = pc;
        @(negedge clk);
        ea = modelFwd(hist[0].rs1);
        eb = modelFwd(hist[0].rs2);
        expLw = hist[0].ld && hist[0].rd != 0 &&
                (hist[0].rd == d.rs1 || hist[0].rd == d.rs2);
        expFlushE = pc || expLw;
        chk("model_fwd_a",   32'(ifc16.forward_a_e), 32'(ea));
        chk("model_fwd_b",   32'(ifc16.forward_b_e), 32'(eb));
        chk("model_stall_f", 32'(ifc16.stall_f),     32'(expLw && !pc));
        chk("model_stall_d", 32'(ifc16.stall_d),     32'(expLw && !pc));
        chk("model_flush_d", 32'(ifc16.flush_d),     32'(pc));
        chk("model_flush_e", 32'(ifc16.flush_e),     32'(expFlushE));
        chk("model_cnt16",   32'(ifc16.stall_cnt),   32'(cnt16));
        chk("model_fwd_a2",  32'(ifc2.forward_a_e),  32'(ea));
        chk("model_stall2",  32'(ifc2.stall_f),      32'(expLw && !pc));
        chk("model_cnt2",    32'(ifc2.stall_cnt),    32'(cnt2));
        $display("cyc rs1=%0d rs2=%0d rd=%0d rw=%0b ld=%0b pc=%0b rst=%0b -> fa=%0b fb=%0b sf=%0b sd=%0b fd=%0b fe=%0b cnt=%0d cnt2=%0d",
                 d.rs1, d.rs2, d.rd, d.rw, d.ld, pc, rst, ifc16.forward_a_e, ifc16.forward_b_e,
                 ifc16.stall_f, ifc16.stall_d, ifc16.flush_d, ifc16.flush_e,
                 ifc16.stall_cnt, ifc2.stall_cnt);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            hist.push_front(expFlushE ? instr_t'('0) : curD);
            hist.pop_back();
            if (expLw && !curPc) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt2 < 3) cnt2++;
            end
        end
        #1;
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++) begin
            step('0, 1'b0);
            adv();
        end
    endtask

    task automatic chkAllZero(string tag);
        chk({tag, "_fa"}, 32'(ifc16.forward_a_e), 32'd0);
        chk({tag, "_fb"}, 32'(ifc16.forward_b_e), 32'd0);
        chk({tag, "_sf"}, 32'(ifc16.stall_f), 32'd0);
        chk({tag, "_fe"}, 32'(ifc16.flush_e), 32'd0);
        chk({tag, "_cnt"}, 32'(ifc16.stall_cnt), 32'd0);
    endtask

    initial begin
        instr_t rnd;
        // 1: reset with random D inputs
        rst = 1'b1;
        rnd = mk($urandom_range(31), $urandom_range(31), $urandom_range(31), 1'b1, 1'b1);
        ifc16.rs1_d = rnd.rs1; ifc16.rs2_d = rnd.rs2; ifc16.rd_d = rnd.rd;
        ifc16.regwrite_d = 1'b1; ifc16.load_d = 1'b1; ifc16.pcsrc_e = 1'b0;
        ifc2.rs1_d = rnd.rs1; ifc2.rs2_d = rnd.rs2; ifc2.rd_d = rnd.rd;
        ifc2.regwrite_d = 1'b1; ifc2.load_d = 1'b1; ifc2.pcsrc_e = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            step(mk($urandom_range(31), $urandom_range(31), $urandom_range(31), 1'b1, 1'b1), 1'b0);
            chkAllZero("reset");
            adv();
        end
        rst = 1'b0;

        // 2: EX->EX forward
        step(mk(1, 2, 5, 1, 0), 1'b0); adv();        // add x5,x1,x2
        step(mk(5, 1, 6, 1, 0), 1'b0); adv();        // sub x6,x5,x1
        step('0, 1'b0);
        chk("exex_fa", 32'(ifc16.forward_a_e), 32'h2);
        chk("exex_fb", 32'(ifc16.forward_b_e), 32'h0);
        chk("exex_muxA", muxA, 32'h3333_0000);
        adv();
        nops(3);

        // 3a: M wins over W
        step(mk(1, 2, 5, 1, 0), 1'b0); adv();
        step(mk(3, 4, 5, 1, 0), 1'b0); adv();
        step(mk(5, 5, 7, 1, 0), 1'b0); adv();        // or x7,x5,x5
        step('0, 1'b0);
        chk("prio_fa", 32'(ifc16.forward_a_e), 32'h2);
        chk("prio_fb", 32'(ifc16.forward_b_e), 32'h2);
        adv();
        nops(3);
        // 3b: WB->EX
        step(mk(1, 2, 5, 1, 0), 1'b0); adv();
        step('0, 1'b0); adv();
        step(mk(5, 5, 7, 1, 0), 1'b0); adv();
        step('0, 1'b0);
        chk("wb_fa", 32'(ifc16.forward_a_e), 32'h1);
        chk("wb_fb", 32'(ifc16.forward_b_e), 32'h1);
        chk("wb_muxA", muxA, 32'h2222_0000);
        adv();
        nops(3);

        // 4: x0 never forwarded
        step(mk(0, 0, 0, 1, 0), 1'b0); adv();        // addi x0,x0,1
        step(mk(0, 0, 8, 1, 0), 1'b0); adv();        // add x8,x0,x0
        step('0, 1'b0);
        chk("x0_fa", 32'(ifc16.forward_a_e), 32'h0);
        chk("x0_fb", 32'(ifc16.forward_b_e), 32'h0);
        adv();
        nops(3);

        // 5: load-use, exactly one stall
        step(mk(1, 0, 9, 1, 1), 1'b0); adv();        // lw x9
        step(mk(9, 2, 10, 1, 0), 1'b0);              // add x10,x9,x2
        chk("lu_sf", 32'(ifc16.stall_f), 32'h1);
        chk("lu_sd", 32'(ifc16.stall_d), 32'h1);
        chk("lu_fe", 32'(ifc16.flush_e), 32'h1);
        chk("lu_cnt0", 32'(ifc16.stall_cnt), 32'd0);
        adv();
        step(mk(9, 2, 10, 1, 0), 1'b0);              // held in D
        chk("lu_nostall", 32'(ifc16.stall_f), 32'h0);
        chk("lu_cnt1", 32'(ifc16.stall_cnt), 32'd1);
        adv();
        step('0, 1'b0);
        chk("lu_fa", 32'(ifc16.forward_a_e), 32'h1);
        adv();
        nops(3);

        // 6: branch beats load-use
        step(mk(1, 0, 11, 1, 1), 1'b0); adv();       // lw x11
        step(mk(11, 3, 12, 1, 0), 1'b1);
        chk("br_fd", 32'(ifc16.flush_d), 32'h1);
        chk("br_fe", 32'(ifc16.flush_e), 32'h1);
        chk("br_sf", 32'(ifc16.stall_f), 32'h0);
        chk("br_sd", 32'(ifc16.stall_d), 32'h0);
        adv();
        step('0, 1'b0);
        chk("br_cnt", 32'(ifc16.stall_cnt), 32'd1);
        adv();
        nops(2);

        // 6b: saturation of the 2-bit counter
        for (int k = 0; k < 4; k++) begin
            step(mk(1, 0, 12, 1, 1), 1'b0); adv();
            step(mk(2, 12, 13, 1, 0), 1'b0); adv();
            step(mk(2, 12, 13, 1, 0), 1'b0); adv();
            step('0, 1'b0); adv();
        end
        step('0, 1'b0);
        chk("sat_cnt16", 32'(ifc16.stall_cnt), 32'd5);
        chk("sat_cnt2", 32'(ifc2.stall_cnt), 32'd3);
        adv();

        // mid-operation reset drops pending stall and forwards
        step(mk(1, 0, 14, 1, 1), 1'b0); adv();
        rst = 1'b1;
        step(mk(14, 0, 15, 1, 0), 1'b0);
        adv();
        rst = 1'b0;
        step(mk(14, 0, 15, 1, 0), 1'b0);
        chkAllZero("midrst");
        adv();
        nops(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
